// File: rtl/z80_bus_master.sv
// Z80 bus initiator: wins the bus via BUSREQ/BUSACK, then runs CPU-style memory/IO cycles.
// Optional grant timeout is enabled with `define BUSACK_TIMEOUT_EN.
module z80_bus_master #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_own,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic        i_cmd_io,
    input  logic [15:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_wdata,
    output logic        o_rsp_valid,
    output logic [7:0]  o_rsp_rdata,
    output logic        o_busreq,
    input  logic        i_busack,
    input  logic        i_wait_n,
    output logic        o_bus_oe,
    output logic [15:0] o_addr,
    output logic        o_mreq,
    output logic        o_iorq,
    output logic        o_rd,
    output logic        o_wr,
    output logic [7:0]  o_data_out,
    output logic        o_data_oe,
    input  logic [7:0]  i_data_in,
    output logic        o_owned,
    output logic        o_err
);

    typedef enum logic [2:0] {
        StIdle, StArb, StOwn, StT1, StT2, StTw, StT3, StRel
    } state_t;

    state_t      r_state, w_state_d;
    logic        r_busack_s1, r_busack_s2;
    logic        r_wait_s1, r_wait_s2;
    logic        r_write, r_io;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [3:0]  r_cnt, w_cnt_d;
    logic        r_rsp_valid;
    logic [7:0]  r_rdata;
    logic        w_busack_s, w_wait_s;
    logic        w_accept;
    logic        w_tmo_hit;
    logic [3:0]  w_load;
    logic        w_cyc, w_data_phase;

    assign w_busack_s = r_busack_s2;
    assign w_wait_s   = r_wait_s2;
    // IO cycles get one automatic Tw, as on the real CPU.
    assign w_load     = 4'(WAIT_STATES) + {3'b000, r_io};

`ifdef BUSACK_TIMEOUT_EN
    logic [15:0] r_tmo;
    logic        r_err;
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_accept  = 1'b0;
        w_tmo_hit = 1'b0;
        case (r_state)
            StIdle: if (i_own) w_state_d = StArb;
            StArb: begin
                if (!i_own) begin
                    w_state_d = StRel;
                end else if (!w_busack_s) begin
                    w_state_d = StOwn;
`ifdef BUSACK_TIMEOUT_EN
                end else if (r_tmo == 16'(TIMEOUT - 1)) begin
                    w_state_d = StRel;
                    w_tmo_hit = 1'b1;
`endif
                end
            end
            StOwn: begin
                if (!i_own) begin
                    w_state_d = StRel;
                end else if (i_cmd_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = StT1;
                end
            end
            StT1: w_state_d = StT2;
            StT2: begin
                w_cnt_d   = w_load;
                w_state_d = (w_load == 4'd0 && w_wait_s) ? StT3 : StTw;
            end
            StTw: begin
                if (r_cnt != 4'd0) w_cnt_d = r_cnt - 4'd1;
                // Last counted Tw (or none left) may exit once WAIT is released.
                if (r_cnt <= 4'd1 && w_wait_s) w_state_d = StT3;
            end
            StT3:    w_state_d = StOwn;
            StRel:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= StIdle;
            r_busack_s1 <= 1'b1;
            r_busack_s2 <= 1'b1;
            r_wait_s1   <= 1'b1;
            r_wait_s2   <= 1'b1;
            r_write     <= 1'b0;
            r_io        <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 8'h00;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 8'h00;
        end else begin
            r_state     <= w_state_d;
            r_busack_s1 <= i_busack;
            r_busack_s2 <= r_busack_s1;
            r_wait_s1   <= i_wait_n;
            r_wait_s2   <= r_wait_s1;
            r_cnt       <= w_cnt_d;
            r_rsp_valid <= (r_state == StT3);
            if (w_accept) begin
                r_write <= i_cmd_write;
                r_io    <= i_cmd_io;
                r_addr  <= i_cmd_addr;
                r_wdata <= i_cmd_wdata;
            end
            if (r_state == StT3 && !r_write) r_rdata <= i_data_in;
        end
    end

`ifdef BUSACK_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tmo <= 16'h0000;
            r_err <= 1'b0;
        end else begin
            r_tmo <= (r_state == StArb && w_state_d == StArb) ? r_tmo + 16'h0001 : 16'h0000;
            r_err <= w_tmo_hit;
        end
    end
`endif

    assign w_cyc        = (r_state == StT2) || (r_state == StTw) || (r_state == StT3);
    assign w_data_phase = w_cyc || (r_state == StT1);

    assign o_owned     = w_data_phase || (r_state == StOwn);
    assign o_busreq    = !((r_state == StArb) || o_owned);
    assign o_bus_oe    = o_owned;
    assign o_cmd_ready = (r_state == StOwn) && i_own;
    assign o_addr      = r_addr;
    assign o_data_out  = r_wdata;
    assign o_data_oe   = w_data_phase && r_write;
    assign o_mreq      = !(w_cyc && !r_io);
    assign o_iorq      = !(w_cyc && r_io);
    assign o_rd        = !(w_cyc && !r_write);
    assign o_wr        = !(w_cyc && r_write);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rdata;

endmodule
